// File: rtl/digit_pair_loader.sv
// Two-digit BCD entry front end: debounced enter/clear keys drive a small FSM
// that latches digit_a then digit_b and flags a complete pair with pair_valid.
module digit_pair_loader #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_enter_n,
    input  logic       key_clear_n,
    input  logic [3:0] sw_digit,
    output logic [3:0] digit_a,
    output logic [3:0] digit_b,
    output logic       pair_valid,
    output logic       entry_err,
    output logic [1:0] state
);

    localparam int unsigned CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned NKEYS     = 2;
    localparam int unsigned KEY_ENTER = 0;
    localparam int unsigned KEY_CLEAR = 1;

    typedef enum logic [1:0] {
        WAIT_A     = 2'd0,
        WAIT_B     = 2'd1,
        PAIR_READY = 2'd2
    } state_t;

    logic [NKEYS-1:0] key_raw;
    logic [NKEYS-1:0] sync1_q;
    logic [NKEYS-1:0] sync2_q;
    logic [NKEYS-1:0] level_q;
    logic [NKEYS-1:0] level_dly_q;
    logic [NKEYS-1:0] press_c;
    logic [CNT_W-1:0] cnt_q [NKEYS];

    state_t     state_q, state_d;
    logic [3:0] digit_a_q, digit_a_d;
    logic [3:0] digit_b_q, digit_b_d;
    logic       pair_valid_q, pair_valid_d;
    logic       entry_err_q, entry_err_d;
    logic       enter_ev_c, clear_ev_c, digit_good_c;

    assign key_raw = {key_clear_n, key_enter_n};

    // Synchronize each raw key, then accept a level change only after
    // DEBOUNCE_CYCLES consecutive mismatching samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            level_q     <= '1;
            level_dly_q <= '1;
            for (int k = 0; k < NKEYS; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            sync1_q     <= key_raw;
            sync2_q     <= sync1_q;
            level_dly_q <= level_q;
            for (int k = 0; k < NKEYS; k++) begin
                if (sync2_q[k] != level_q[k]) begin
                    if (cnt_q[k] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        level_q[k] <= sync2_q[k];
                        cnt_q[k]   <= '0;
                    end else begin
                        cnt_q[k] <= cnt_q[k] + CNT_W'(1);
                    end
                end else begin
                    cnt_q[k] <= '0;
                end
            end
        end
    end

    // Falling edge of the debounced level is a press; releases are ignored.
    assign press_c      = ~level_q & level_dly_q;
    assign clear_ev_c   = press_c[KEY_CLEAR];
    assign enter_ev_c   = press_c[KEY_ENTER];
    assign digit_good_c = (sw_digit <= 4'd9);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= WAIT_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear_ev_c) begin
            state_d = WAIT_A;
        end else begin
            case (state_q)
                WAIT_A:     if (enter_ev_c && digit_good_c) state_d = WAIT_B;
                WAIT_B:     if (enter_ev_c && digit_good_c) state_d = PAIR_READY;
                PAIR_READY: if (enter_ev_c && digit_good_c) state_d = WAIT_B;
                default:    state_d = WAIT_A;
            endcase
        end
    end

    // Clear and the unused encoding both return the datapath to its reset values.
    always_comb begin
        digit_a_d    = digit_a_q;
        digit_b_d    = digit_b_q;
        pair_valid_d = pair_valid_q;
        entry_err_d  = entry_err_q;
        if (clear_ev_c) begin
            digit_a_d    = 4'd0;
            digit_b_d    = 4'd0;
            pair_valid_d = 1'b0;
            entry_err_d  = 1'b0;
        end else begin
            case (state_q)
                WAIT_A: begin
                    if (enter_ev_c) begin
                        entry_err_d = !digit_good_c;
                        if (digit_good_c) digit_a_d = sw_digit;
                    end
                end
                WAIT_B: begin
                    if (enter_ev_c) begin
                        entry_err_d = !digit_good_c;
                        if (digit_good_c) begin
                            digit_b_d    = sw_digit;
                            pair_valid_d = 1'b1;
                        end
                    end
                end
                PAIR_READY: begin
                    if (enter_ev_c) begin
                        entry_err_d = !digit_good_c;
                        if (digit_good_c) begin
                            digit_a_d    = sw_digit;
                            digit_b_d    = 4'd0;
                            pair_valid_d = 1'b0;
                        end
                    end
                end
                default: begin
                    digit_a_d    = 4'd0;
                    digit_b_d    = 4'd0;
                    pair_valid_d = 1'b0;
                    entry_err_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digit_a_q    <= 4'd0;
            digit_b_q    <= 4'd0;
            pair_valid_q <= 1'b0;
            entry_err_q  <= 1'b0;
        end else begin
            digit_a_q    <= digit_a_d;
            digit_b_q    <= digit_b_d;
            pair_valid_q <= pair_valid_d;
            entry_err_q  <= entry_err_d;
        end
    end

    assign digit_a    = digit_a_q;
    assign digit_b    = digit_b_q;
    assign pair_valid = pair_valid_q;
    assign entry_err  = entry_err_q;
    assign state      = state_q;

endmodule

// File: tb/tb_digit_pair_loader.sv
// Scoreboard bench for digit_pair_loader: directed key presses push expected
// output tuples with their due edge; a negedge monitor checks every cycle.
module tb_digit_pair_loader;

    localparam int D = 4;

    typedef struct {
        int         cyc;
        logic [1:0] st;
        logic [3:0] a;
        logic [3:0] b;
        logic       pv;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       key_enter_n = 1'b1;
    logic       key_clear_n = 1'b1;
    logic [3:0] sw_digit = 4'd0;
    logic [3:0] digit_a, digit_b;
    logic       pair_valid, entry_err;
    logic [1:0] state;

    int   edge_cnt = 0;
    int   total = 0;
    int   bad = 0;
    bit   done = 1'b0;
    exp_t q[$];
    exp_t cur;

    digit_pair_loader #(.DEBOUNCE_CYCLES(D)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .key_enter_n(key_enter_n),
        .key_clear_n(key_clear_n),
        .sw_digit   (sw_digit),
        .digit_a    (digit_a),
        .digit_b    (digit_b),
        .pair_valid (pair_valid),
        .entry_err  (entry_err),
        .state      (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    function automatic exp_t mk(input logic [1:0] st, input logic [3:0] a,
                                input logic [3:0] b, input logic pv, input logic err);
        exp_t e;
        e.cyc = 0;
        e.st  = st;
        e.a   = a;
        e.b   = b;
        e.pv  = pv;
        e.err = err;
        return e;
    endfunction

    // Monitor: adopt the next expected tuple on its due edge, compare every cycle.
    initial begin
        cur = mk(2'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        while (!done) begin
            @(negedge clk);
            if (done) break;
            if (!reset_n) begin
                cur = mk(2'd0, 4'd0, 4'd0, 1'b0, 1'b0);
            end else if (q.size() > 0 && q[0].cyc <= edge_cnt) begin
                if (q[0].cyc < edge_cnt) begin
                    total++;
                    bad++;
                    $display("FAIL missed_update: edge=%0d required_edge=%0d", edge_cnt, q[0].cyc);
                end
                cur = q.pop_front();
            end
            total++;
            if (state !== cur.st || digit_a !== cur.a || digit_b !== cur.b ||
                pair_valid !== cur.pv || entry_err !== cur.err) begin
                bad++;
                $display("FAIL outputs@edge%0d: got st=%0d a=%0d b=%0d pv=%0b err=%0b required st=%0d a=%0d b=%0d pv=%0b err=%0b",
                         edge_cnt, state, digit_a, digit_b, pair_valid, entry_err,
                         cur.st, cur.a, cur.b, cur.pv, cur.err);
            end
        end
    end

    // Press one or both keys; the expected tuple is due D+2 edges after edge 0.
    task automatic press(input logic [3:0] d, input bit ent, input bit clr,
                         input exp_t e, input int hold);
        @(posedge clk);
        #1;
        sw_digit = d;
        if (ent) key_enter_n = 1'b0;
        if (clr) key_clear_n = 1'b0;
        e.cyc = edge_cnt + 1 + D + 2;
        q.push_back(e);
        repeat (hold) @(posedge clk);
        #1;
        key_enter_n = 1'b1;
        key_clear_n = 1'b1;
        repeat (D + 4) @(posedge clk);
    endtask

    initial begin
        #22 reset_n = 1'b1;
        repeat (3) @(posedge clk);

        // Basic pair entry 3,3 then clear
        press(4'd3, 1, 0, mk(2'd1, 4'd3, 4'd0, 1'b0, 1'b0), D + 3);
        press(4'd3, 1, 0, mk(2'd2, 4'd3, 4'd3, 1'b1, 1'b0), D + 3);
        press(4'd0, 0, 1, mk(2'd0, 4'd0, 4'd0, 1'b0, 1'b0), D + 3);

        // Bounce: 3 low, 1 high, 3 low never reaches D mismatches
        @(posedge clk);
        #1 key_enter_n = 1'b0;
        sw_digit = 4'd4;
        repeat (3) @(posedge clk);
        #1 key_enter_n = 1'b1;
        @(posedge clk);
        #1 key_enter_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 key_enter_n = 1'b1;
        repeat (D + 4) @(posedge clk);
        press(4'd4, 1, 0, mk(2'd1, 4'd4, 4'd0, 1'b0, 1'b0), 6);
        press(4'd0, 0, 1, mk(2'd0, 4'd0, 4'd0, 1'b0, 1'b0), D + 3);

        // Bad digit in WAIT_A, then recovery
        press(4'd12, 1, 0, mk(2'd0, 4'd0, 4'd0, 1'b0, 1'b1), D + 3);
        press(4'd7,  1, 0, mk(2'd1, 4'd7, 4'd0, 1'b0, 1'b0), D + 3);

        // Pair 5,9 then bad and good entries from PAIR_READY
        press(4'd0,  0, 1, mk(2'd0, 4'd0, 4'd0, 1'b0, 1'b0), D + 3);
        press(4'd5,  1, 0, mk(2'd1, 4'd5, 4'd0, 1'b0, 1'b0), D + 3);
        press(4'd9,  1, 0, mk(2'd2, 4'd5, 4'd9, 1'b1, 1'b0), D + 3);
        press(4'd15, 1, 0, mk(2'd2, 4'd5, 4'd9, 1'b1, 1'b1), D + 3);
        press(4'd2,  1, 0, mk(2'd1, 4'd2, 4'd0, 1'b0, 1'b0), D + 3);
        press(4'd10, 1, 0, mk(2'd1, 4'd2, 4'd0, 1'b0, 1'b1), D + 3);

        // Clear and enter together in WAIT_B, held long: clear wins, no repeats
        press(4'd8, 1, 1, mk(2'd0, 4'd0, 4'd0, 1'b0, 1'b0), 3 * D + 6);

        // Reset mid-debounce with key still held at release
        press(4'd1, 1, 0, mk(2'd1, 4'd1, 4'd0, 1'b0, 1'b0), D + 3);
        @(posedge clk);
        #1 key_enter_n = 1'b0;
        sw_digit = 4'd6;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b0;
        q.delete();
        #1;
        total++;
        if (state !== 2'd0 || digit_a !== 4'd0 || pair_valid !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: got st=%0d a=%0d pv=%0b required st=0 a=0 pv=0",
                     state, digit_a, pair_valid);
        end
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        begin
            exp_t e;
            e = mk(2'd1, 4'd6, 4'd0, 1'b0, 1'b0);
            e.cyc = edge_cnt + 1 + D + 2;
            q.push_back(e);
        end
        repeat (3 * D) @(posedge clk);
        #1 key_enter_n = 1'b1;
        repeat (2 * D + 4) @(posedge clk);

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL pending_updates: got %0d left required 0", q.size());
        end
        @(negedge clk);
        done = 1'b1;
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/digit_pair_loader.md
# digit_pair_loader

Sequential front end for the two-digit equality checker: lets the user enter two BCD digits one at a time from a 4-bit switch group using a debounced "enter" pushbutton, and presents them as a registered pair (`digit_a`, `digit_b`) with a `pair_valid` qualifier. It sits directly upstream of the comparator, replacing the fixed `SW[3:0]` / `SW[7:4]` split with timed, validated entry. A separate "clear" button aborts entry at any point.

## Interface
- `DEBOUNCE_CYCLES`, default 16: number of consecutive synchronized-stable cycles required before a key level change is accepted.
  - Range is ≥2.
  - Board build overrides this to 500000 (10 ms at 50 MHz).
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `key_enter_n`, input, 1: raw active-low pushbutton (KEY), asynchronous to `clk`, bouncy.
- `key_clear_n`, input, 1: raw active-low pushbutton, same properties as `key_enter_n`.
- `sw_digit`, input, 4: digit to load, sampled on an accepted enter press. This input is quasi-static and is not synchronized.
- `digit_a`, output, 4: first latched digit (registered).
- `digit_b`, output, 4: second latched digit (registered).
- `pair_valid`, output, 1: high while both digits are loaded (registered).
- `entry_err`, output, 1: sticky flag set by an attempted load of a non-BCD value (registered).
- `state`, output, 2: current FSM state for LED display. Encoding is `WAIT_A`=0, `WAIT_B`=1, `PAIR_READY`=2; 3 is unused.

## Operation
**Key conditioning (one instance per key, identical):**
- Two-flop synchronizer; both flops reset to 1 (released).
- Debounced level register resets to 1.
- Counter, `$clog2(DEBOUNCE_CYCLES+1)` bits, resets to 0.
  - Each edge where sync output ≠ debounced level: counter increments.
  - Each edge where they are equal: counter clears to 0.
  - On the edge where the counter would reach `DEBOUNCE_CYCLES`: debounced level takes the sync value and the counter clears.
- Press event: one-cycle pulse while debounced level is 0 and its one-cycle-delayed copy is 1.
  - The delayed copy resets to 1.
  - A release produces no event.

**FSM (states `WAIT_A`, `WAIT_B`, `PAIR_READY`):**
- A "good" digit is `sw_digit` ≤ 9; a "bad" digit is 10–15.
- Clear event, any state → `WAIT_A`; `digit_a`=`digit_b`=0, `pair_valid`=0, `entry_err`=0.
- Clear and enter events in the same cycle: clear wins and enter is discarded.
- `WAIT_A` + enter:
  - Good digit: `digit_a`←`sw_digit`, `entry_err`←0, go to `WAIT_B`.
  - Bad digit: `entry_err`←1, stay; `digit_a` unchanged.
- `WAIT_B` + enter:
  - Good digit: `digit_b`←`sw_digit`, `entry_err`←0, `pair_valid`←1, go to `PAIR_READY`.
  - Bad digit: `entry_err`←1, stay.
- `PAIR_READY` + enter (starts a new pair):
  - Good digit: `digit_a`←`sw_digit`, `digit_b`←0, `pair_valid`←0, `entry_err`←0, go to `WAIT_B`.
  - Bad digit: `entry_err`←1; pair, `pair_valid` and state are retained.
- `PAIR_READY` with no event: hold indefinitely.
- Illegal state encoding 3: the next edge forces `WAIT_A` with the clear actions applied.

## Timing
- Reset (asynchronous, immediate): `digit_a`=0, `digit_b`=0, `pair_valid`=0, `entry_err`=0, `state`=0. Synchronizers, debounced levels and delayed copies are 1; counters are 0.
- Deassertion of reset is synchronized externally (board level). The block assumes `reset_n` releases away from a `clk` edge.
- Press latency (edge 0 = first edge sampling raw low; raw held low throughout; D = `DEBOUNCE_CYCLES`):
  - sync output is 0 after edge 1;
  - debounced level flips at edge D+1;
  - press pulse is high during cycle D+1→D+2;
  - FSM outputs update at edge D+2.
- Bounce: any return of the sync output to the debounced level before D consecutive mismatches restarts the count. No event is generated.
- Key held across reset deassertion is treated as a new press: one event after D+2 edges.
- Holding a key generates exactly one event. Another event requires a debounced release (D stable-high cycles) followed by a new debounced press.
- Reset asserted mid-debounce or mid-entry aborts everything and restores reset values. No event is emitted from pre-reset activity.
- Consumer contract: `digit_a`/`digit_b` are only meaningful to the comparator while `pair_valid`=1. They change only on the edge that also updates `pair_valid` or `state`.

## Test plan
All scenarios use D=4.
- Reset, then enter with `sw_digit`=3, then enter with `sw_digit`=3: `digit_a`=3 at edge 6 after the first press; then `digit_b`=3, `pair_valid`=1, `state`=2.
- Bounce: `key_enter_n` low for 3 cycles, high for 1, low for 3, then high: no event, and `state` stays 0. Then hold low for 6 cycles: exactly one event.
- Bad digit: in `WAIT_A` enter with 12 → `entry_err`=1, `state`=0, `digit_a`=0. Enter with 7 → `entry_err`=0, `digit_a`=7, `state`=1.
- `PAIR_READY` (pair 5,9):
  - Enter with 2 → `digit_a`=2, `digit_b`=0, `pair_valid`=0, `state`=1.
  - Enter with 15 from `PAIR_READY` instead → pair 5,9 retained, `entry_err`=1.
- Simultaneous clear and enter pulses in `WAIT_B` → `state`=0, digits 0, `pair_valid`=0. Held key produces no repeat events.
- Assert `reset_n` low mid-debounce, with key still held at release → outputs reset immediately; one press event D+2 edges after reset release.
